// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin load-fetch engine. Several clients share one
// downstream read port; the granted client's line is assembled from response
// beats and returned with its byte offset and the count of valid bytes.
module mem_request_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_fetch_ad,
  input  logic [NUM_CLIENTS-1:0]            cli_send_fetch_req,
  output logic [NUM_CLIENTS-1:0]            cli_mem_req_completed,
  output logic [0:LINE_BYTES*8-1]           cli_mem_buffer,
  output logic [$clog2(LINE_BYTES):0]       cli_buf_offset,
  output logic [$clog2(LINE_BYTES):0]       cli_num_bytes,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [TAG_WIDTH-1:0]              mem_req_tag,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_resp_data,
  input  logic [TAG_WIDTH-1:0]              mem_resp_tag
);

  localparam int unsigned LINE_BITS = LINE_BYTES * 8;
  localparam int unsigned BEATS     = LINE_BITS / DATA_WIDTH;
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES) + 1;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    DONE
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        gnt_idx;
  logic [CNT_W-1:0]        beat_cnt;
  logic [NUM_CLIENTS-1:0]  mask;
  logic [ADDR_WIDTH-1:0]   addr_q;

  logic [NUM_CLIENTS-1:0]  eligible_c;
  logic                    found_c;
  logic [IDX_W-1:0]        pick_c;
  logic [ADDR_WIDTH-1:0]   pick_addr_c;
  logic [OFF_W-1:0]        offset_c;
  logic                    beat_hit_c;
  int unsigned             best_dist_c;
  int unsigned             dist_c;

  // Round-robin pick: eligible client with the smallest cyclic distance from rr_ptr
  always_comb begin
    eligible_c  = cli_send_fetch_req & ~mask;
    found_c     = 1'b0;
    pick_c      = '0;
    best_dist_c = NUM_CLIENTS;
    dist_c      = 0;
    for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
      dist_c = (c + NUM_CLIENTS - 32'(rr_ptr)) % NUM_CLIENTS;
      if (eligible_c[c] && (dist_c < best_dist_c)) begin
        best_dist_c = dist_c;
        pick_c      = IDX_W'(c);
        found_c     = 1'b1;
      end
    end
  end

  // Address of the picked client, line offset of the latched request, beat filter
  always_comb begin
    pick_addr_c = cli_fetch_ad[pick_c*ADDR_WIDTH +: ADDR_WIDTH];
    offset_c    = OFF_W'(addr_q & OFF_MASK);
    beat_hit_c  = mem_resp_valid && (mem_resp_tag == TAG_WIDTH'(gnt_idx));
  end

  // Control FSM with registered request, buffer and completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      rr_ptr                <= '0;
      gnt_idx               <= '0;
      beat_cnt              <= '0;
      mask                  <= '0;
      addr_q                <= '0;
      cli_mem_req_completed <= '0;
      cli_mem_buffer        <= '0;
      cli_buf_offset        <= '0;
      cli_num_bytes         <= '0;
      mem_req_valid         <= 1'b0;
      mem_req_addr          <= '0;
      mem_req_tag           <= '0;
    end else begin
      case (state)
        IDLE: begin
          // the completed client is masked only for this single cycle
          mask <= '0;
          if (found_c) begin
            gnt_idx       <= pick_c;
            addr_q        <= pick_addr_c;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= pick_addr_c & ~OFF_MASK;
            mem_req_tag   <= TAG_WIDTH'(pick_c);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= COLLECT;
          end
        end
        COLLECT: begin
          if (beat_hit_c) begin
            // beat 0 lands at the MSB end of the line
            cli_mem_buffer[beat_cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_resp_data;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              cli_mem_req_completed <= NUM_CLIENTS'(1) << gnt_idx;
              cli_buf_offset        <= offset_c;
              cli_num_bytes         <= OFF_W'(LINE_BYTES) - offset_c;
              state                 <= DONE;
            end
          end
        end
        DONE: begin
          cli_mem_req_completed <= '0;
          rr_ptr                <= IDX_W'((32'(gnt_idx) + 1) % NUM_CLIENTS);
          mask                  <= NUM_CLIENTS'(1) << gnt_idx;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: random client rounds predicted by a
// transaction-level round-robin model, a reactive memory model, and a
// completion monitor draining a scoreboard queue.
module tb_mem_request_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned DW    = 64;
  localparam int unsigned LB    = 64;
  localparam int unsigned AW    = 64;
  localparam int unsigned TW    = 1;
  localparam int unsigned LBITS = LB * 8;
  localparam int unsigned BEATS = LBITS / DW;
  localparam int unsigned OW    = $clog2(LB) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   cli_fetch_ad;
  logic [N-1:0]      cli_send_fetch_req;
  logic [N-1:0]      cli_mem_req_completed;
  logic [0:LBITS-1]  cli_mem_buffer;
  logic [OW-1:0]     cli_buf_offset;
  logic [OW-1:0]     cli_num_bytes;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic [TW-1:0]     mem_resp_tag;

  mem_request_arbiter #(
    .NUM_CLIENTS(N), .DATA_WIDTH(DW), .LINE_BYTES(LB), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cli_fetch_ad          (cli_fetch_ad),
    .cli_send_fetch_req    (cli_send_fetch_req),
    .cli_mem_req_completed (cli_mem_req_completed),
    .cli_mem_buffer        (cli_mem_buffer),
    .cli_buf_offset        (cli_buf_offset),
    .cli_num_bytes         (cli_num_bytes),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_addr          (mem_req_addr),
    .mem_req_tag           (mem_req_tag),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_data         (mem_resp_data),
    .mem_resp_tag          (mem_resp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              client;
    int              offset;
    int              nbytes;
    logic [LBITS-1:0] data;
  } cmp_t;

  typedef struct {
    logic [AW-1:0] line;
    logic [TW-1:0] tag;
  } req_t;

  cmp_t          cmp_q[$];
  req_t          req_q[$];
  int            total = 0;
  int            bad   = 0;
  int            model_ptr = 0;
  bit            granted[N];
  bit            abort_mode = 0;
  bit            abort_go   = 0;
  bit [N-1:0]    r_set;
  bit [N-1:0]    r_again;
  logic [AW-1:0] r_addr1[N];
  logic [AW-1:0] r_addr2[N];

  // memory content: a fixed function of line address and beat number
  function automatic logic [DW-1:0] beat_val(input logic [AW-1:0] line, input int b);
    logic [63:0] v;
    v = {line[47:0] ^ 48'h5a3c_96e1_0f0f, 8'(b), 8'hc3};
    return DW'(v);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    int            sel;
    a   = AW'({$urandom, $urandom});
    sel = int'($urandom_range(0, 3));
    if (sel == 0) a = a & ~AW'(LB - 1);
    else if (sel == 1) a = a | AW'(LB - 1);
    return a;
  endfunction

  task automatic check(input string name, input logic [LBITS-1:0] act, input logic [LBITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_completed"}, LBITS'(cli_mem_req_completed), '0);
    check({tag, "_req_valid"}, LBITS'(mem_req_valid), '0);
    check({tag, "_req_addr"},  LBITS'(mem_req_addr), '0);
    check({tag, "_req_tag"},   LBITS'(mem_req_tag), '0);
    check({tag, "_offset"},    LBITS'(cli_buf_offset), '0);
    check({tag, "_num_bytes"}, LBITS'(cli_num_bytes), '0);
    check({tag, "_buffer"},    LBITS'(cli_mem_buffer), '0);
  endtask

  // expected downstream request and client completion for one serviced request
  function automatic void push_expect(input int g, input logic [AW-1:0] a);
    cmp_t             c;
    req_t             r;
    logic [LBITS-1:0] d;
    logic [AW-1:0]    line;
    int               off;
    off  = int'(a % AW'(LB));
    line = a - AW'(off);
    d    = '0;
    for (int b = 0; b < int'(BEATS); b++) d = (d << DW) | LBITS'(beat_val(line, b));
    r.line   = line;
    r.tag    = TW'(g);
    c.client = g;
    c.offset = off;
    c.nbytes = int'(LB) - off;
    c.data   = d;
    req_q.push_back(r);
    cmp_q.push_back(c);
  endfunction

  // service order: repeatedly the first pending client at or after the pointer
  task automatic model_round();
    bit            pend[N];
    bit            again[N];
    logic [AW-1:0] cur[N];
    int            g;
    for (int i = 0; i < int'(N); i++) begin
      pend[i]  = r_set[i];
      again[i] = r_again[i];
      cur[i]   = r_addr1[i];
    end
    forever begin
      g = -1;
      for (int k = 0; k < int'(N); k++) begin
        int c;
        c = (model_ptr + k) % int'(N);
        if (g < 0 && pend[c]) g = c;
      end
      if (g < 0) break;
      push_expect(g, cur[g]);
      pend[g] = 0;
      if (again[g]) begin
        again[g] = 0;
        pend[g]  = 1;
        cur[g]   = r_addr2[g];
      end
      model_ptr = (g + 1) % int'(N);
    end
  endtask

  task automatic drive_round();
    int rearm[N];
    bit left[N];
    int cyc;
    for (int i = 0; i < int'(N); i++) begin
      left[i]    = r_again[i];
      rearm[i]   = 0;
      granted[i] = 0;
      if (r_set[i]) begin
        cli_fetch_ad[i*AW +: AW] = r_addr1[i];
        cli_send_fetch_req[i]    = 1'b1;
      end
    end
    cyc = 0;
    while (cmp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < int'(N); i++) begin
        if (cli_mem_req_completed[i]) begin
          cli_send_fetch_req[i] = 1'b0;
          granted[i] = 0;
          if (left[i]) begin
            left[i]  = 0;
            rearm[i] = 2;
          end
        end else if (rearm[i] > 0) begin
          rearm[i]--;
          if (rearm[i] == 0) begin
            cli_fetch_ad[i*AW +: AW] = r_addr2[i];
            cli_send_fetch_req[i]    = 1'b1;
          end
        end else if (granted[i]) begin
          // after grant the address is irrelevant and the request may be dropped
          cli_fetch_ad[i*AW +: AW] = rand_addr();
          if ($urandom_range(0, 5) == 0) cli_send_fetch_req[i] = 1'b0;
        end else if (!cli_send_fetch_req[i]) begin
          cli_fetch_ad[i*AW +: AW] = rand_addr();
        end
      end
    end
    if (cmp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL round_timeout: got %0d pending completions want 0", cmp_q.size());
      cmp_q.delete();
      req_q.delete();
    end
    cli_send_fetch_req = '0;
    repeat (3) @(negedge clk);
  endtask

  // completion monitor
  initial begin : monitor
    cmp_t       c;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && cli_mem_req_completed != '0) begin
        check("completion_onehot", LBITS'($onehot(cli_mem_req_completed)), LBITS'(1));
        if (cmp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion: got %b want none", cli_mem_req_completed);
        end else begin
          c  = cmp_q.pop_front();
          oh = N'(1) << c.client;
          check("completion_client", LBITS'(cli_mem_req_completed), LBITS'(oh));
          check("buf_offset", LBITS'(cli_buf_offset), LBITS'(c.offset));
          check("num_bytes",  LBITS'(cli_num_bytes),  LBITS'(c.nbytes));
          check("line_data",  LBITS'(cli_mem_buffer), c.data);
        end
      end
    end
  end

  // downstream memory: back-pressure, tag-filtered beats with noise
  initial begin : mem_model
    logic [AW-1:0] a0;
    logic [TW-1:0] t0;
    logic [N-1:0]  oh;
    req_t          r;
    int            waits;
    bit            aborted;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_tag   = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (reset === 1'b1 && mem_req_valid === 1'b1) begin
        a0    = mem_req_addr;
        t0    = mem_req_tag;
        waits = int'($urandom_range(0, 6));
        for (int w = 0; w < waits; w++) begin
          mem_req_ready  = 1'b0;
          mem_resp_valid = ($urandom_range(0, 2) == 0);
          mem_resp_tag   = t0;
          mem_resp_data  = DW'({$urandom, $urandom});
          @(negedge clk);
          check("hold_valid", LBITS'(mem_req_valid), LBITS'(1));
          check("hold_addr",  LBITS'(mem_req_addr),  LBITS'(a0));
          check("hold_tag",   LBITS'(mem_req_tag),   LBITS'(t0));
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_request: got addr %0h tag %0d want none", mem_req_addr, mem_req_tag);
        end else begin
          r = req_q.pop_front();
          check("req_addr", LBITS'(mem_req_addr), LBITS'(r.line));
          check("req_tag",  LBITS'(mem_req_tag),  LBITS'(r.tag));
        end
        if (int'(t0) < int'(N)) granted[int'(t0)] = 1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        aborted = 0;
        for (int b = 0; b < int'(BEATS); b++) begin
          if (abort_mode && b == 4) begin
            mem_resp_valid = 1'b0;
            abort_go = 1;
            for (int w = 0; w < 100 && reset === 1'b1; w++) @(negedge clk);
            for (int s = 0; s < 8; s++) begin
              mem_resp_valid = 1'b1;
              mem_resp_tag   = t0;
              mem_resp_data  = DW'({$urandom, $urandom});
              @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            abort_go = 0;
            aborted  = 1;
            break;
          end
          while ($urandom_range(0, 2) == 0) begin
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_tag   = t0 ^ TW'(1);
            mem_resp_data  = DW'({$urandom, $urandom});
            @(negedge clk);
          end
          mem_resp_valid = 1'b1;
          mem_resp_tag   = t0;
          mem_resp_data  = beat_val(a0, b);
          @(negedge clk);
        end
        if (!aborted) begin
          oh = N'(1) << t0;
          check("done_latency", LBITS'(cli_mem_req_completed), LBITS'(oh));
          // a matching-tag beat during the completion cycle must be ignored
          mem_resp_valid = 1'($urandom_range(0, 1));
          mem_resp_tag   = t0;
          mem_resp_data  = DW'({$urandom, $urandom});
        end
      end
    end
  end

  initial begin : main
    reset              = 1'b0;
    cli_send_fetch_req = '0;
    cli_fetch_ad       = '0;
    r_set              = '0;
    r_again            = '0;
    for (int i = 0; i < int'(N); i++) begin
      r_addr1[i] = '0;
      r_addr2[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single client, mid-line address
    r_set = 2'b01; r_again = 2'b00;
    r_addr1[0] = 64'h0000_0000_1000_0028;
    model_round(); drive_round();

    // contention with a back-to-back re-request from client 0
    r_set = 2'b11; r_again = 2'b01;
    r_addr1[0] = 64'h0000_0000_2000_0100;
    r_addr1[1] = 64'h0000_0000_3000_0010;
    r_addr2[0] = 64'h0000_0000_4000_003f;
    model_round(); drive_round();

    // line-aligned address on client 1
    r_set = 2'b10; r_again = 2'b00;
    r_addr1[1] = 64'hABCD_0000_0000_1240;
    model_round(); drive_round();

    for (int n = 0; n < 30; n++) begin
      r_set = N'($urandom_range(1, (1 << N) - 1));
      r_again = N'($urandom) & r_set;
      for (int i = 0; i < int'(N); i++) begin
        r_addr1[i] = rand_addr();
        r_addr2[i] = rand_addr();
      end
      model_round(); drive_round();
    end

    // reset in the middle of collecting a line
    abort_mode = 1;
    push_expect(0, 64'h0000_0000_5000_0008);
    cli_fetch_ad[0 +: AW] = 64'h0000_0000_5000_0008;
    cli_send_fetch_req    = 2'b01;
    for (int w = 0; w < 400 && !abort_go; w++) @(posedge clk);
    if (!abort_go) begin
      total++;
      bad++;
      $display("FAIL abort_wait: got no mid-line point want beat 4 reached");
    end
    #1;
    reset = 1'b0;
    cli_send_fetch_req = '0;
    if (cmp_q.size() != 0) void'(cmp_q.pop_front());
    req_q.delete();
    for (int i = 0; i < int'(N); i++) granted[i] = 0;
    model_ptr = 0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    abort_mode = 0;
    repeat (12) @(negedge clk);

    // normal service after the aborted line
    r_set = 2'b11; r_again = 2'b10;
    r_addr1[0] = 64'h0000_0000_6000_0004;
    r_addr1[1] = 64'h0000_0000_7000_0000;
    r_addr2[1] = 64'h0000_0000_8000_0021;
    model_round(); drive_round();

    check("leftover_requests",    LBITS'(req_q.size()), '0);
    check("leftover_completions", LBITS'(cmp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
